jh_stream_upsizer: RTL
======================

// Module: jh_stream_upsizer
// PURPOSE
//  Downstream neighbour of the 2-cycle single-port-RAM sync FIFO. Consumes its narrow
//  valid/ready output stream and packs RATIO consecutive words into one wide word for a
//  wide sink (bus master / wide RAM). Sustains 1 narrow word/cycle; adds 1 cycle latency.
// PARAMETERS
//  DATA_WIDTH  8  narrow input word width
//  RATIO       4  narrow words per wide word; power of 2, >=2
//  localparam OUT_WIDTH = DATA_WIDTH*RATIO; LB_RATIO = $clog2(RATIO)
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rstn       in   1            async active-low reset
//  in_data    in   DATA_WIDTH   narrow word (from FIFO out_data)
//  in_valid   in   1            narrow word valid
//  in_ready   out  1            block accepts narrow word
//  out_data   out  OUT_WIDTH    packed word, lane 0 = first-received = LSBs
//  out_valid  out  1            packed word valid (registered)
//  out_ready  in   1            sink accepts packed word
//  clear      in   1            sync flush, priority over all traffic
//  count      out  LB_RATIO+1   lanes currently held in accumulator (0..RATIO-1)
//  [in_last, out_last, out_keep: see CONFIGURATION]
// BEHAVIOUR
//  - Reset (rstn=0, async) and clear (sync): lane_r=0, acc_r=0, out_data=0, out_valid=0,
//    count=0; any partial word and any held output word are discarded. clear wins over
//    simultaneous in/out handshakes; no transfer counted that cycle.
//  - in_exec = in_valid & in_ready; out_exec = out_valid & out_ready.
//  - in_ready = (lane_r != RATIO-1) | !out_valid | out_ready (combinational on out_ready).
//  - in_exec, lane_r < RATIO-1: acc_r lane[lane_r] <= in_data; lane_r++.
//  - in_exec, lane_r == RATIO-1: out_data <= {in_data, acc_r[lanes 0..RATIO-2]};
//    out_valid <= 1; lane_r <= 0 (wrap). acc_r not cleared (stale lanes not visible).
//  - out_exec without new completion: out_valid <= 0; out_data holds last value.
//  - Simultaneous out_exec and completion: out_valid stays 1, out_data replaced; no bubble.
//  - out_data/out_valid stable while out_valid & !out_ready (AXI-style hold).
//  - Latency: last lane accepted in cycle N -> out_valid in N+1.
//  - Throughput: RATIO narrow words per RATIO cycles with out_ready=1.
//  - Backpressure: only last lane stalls; lanes 0..RATIO-2 always accepted.
//  - count = lane_r, zero-extended; never reaches RATIO.
// CONFIGURATION
//  Macro JH_STREAM_UPSIZER_LAST_EN:
//  defined:
//   - adds in_last (in,1), out_last (out,1), out_keep (out,RATIO).
//   - in_exec with in_last=1 completes the word at any lane_r; unfilled upper lanes = 0.
//   - out_keep bit i = 1 for lanes 0..lane_r; out_last = 1.
//   - in_ready rule applies to any word that would complete.
//   - full word without in_last: out_last=0, out_keep='1.
//  undefined: ports absent; only full RATIO-lane words emitted; behaviour as above.
// STRUCTURE
//  - Package jh_stream_pkg:
//    typedef lane_idx_t (LB_RATIO bits); function ratio_ok() for parameter
//    elaboration check (RATIO power of 2, >=2).
//  - One sub-module, jh_stream_out_reg: output holding register with valid/ready,
//    load/hold/drain logic and optional last/keep fields.
//  - Top keeps lane counter, accumulator, in_ready.
// TESTING (DATA_WIDTH=8, RATIO=4)
//  1 In 01,02,03,04 back-to-back, out_ready=1
//    -> out_data=32'h04030201 one cycle after 04; count 0,1,2,3,0.
//  2 Streaming 01..08 continuous, out_ready=1
//    -> 04030201 then 08070605 on consecutive completions; in_ready never 0.
//  3 Word 1 held (out_ready=0), lanes 05,06,07 sent
//    -> in_ready=0 at lane 3; out_ready=1 -> 08070605 follows, no bubble.
//  4 Two lanes in (count=2), clear=1 with in_valid=1
//    -> count=0, out_valid=0; next 4 words pack cleanly.
//  5 rstn low mid-word with out_valid=1
//    -> immediately out_valid=0, count=0, out_data=0.
//  6 LAST_EN: 0A,0B with in_last on 0B
//    -> out_data=32'h00000B0A, out_keep=4'b0011, out_last=1.

Source files
------------

// File: rtl/jh_stream_pkg.sv
// jh_stream_pkg: shared types and helpers for the narrow-to-wide stream upsizer.
//   lane_idx_t : lane index for the default ratio (4 lanes -> 2 bits)
//   ratio_ok() : elaboration-time legality check for the RATIO parameter
package jh_stream_pkg;

  localparam int unsigned JH_DEF_DATA_WIDTH = 8;
  localparam int unsigned JH_DEF_RATIO      = 4;

  typedef logic [$clog2(JH_DEF_RATIO)-1:0] lane_idx_t;

  // RATIO must be a power of two and at least 2 so the lane counter wraps naturally.
  function automatic bit ratio_ok(input int unsigned ratio);
    return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
  endfunction

endpackage

// File: rtl/jh_stream_out_reg.sv
// jh_stream_out_reg: wide-word output holding register with valid/ready.
//   Loads a completed word, holds it stable while the sink stalls, drains it on
//   handshake. A load in the same cycle as a drain replaces the word with no bubble.
// Ports:
//   clk, rstn             clock, async active-low reset
//   clear                 sync flush, highest priority
//   load, load_data       completed word from the packer
//   load_last, load_keep  packet end / lane-valid mask (JH_STREAM_UPSIZER_LAST_EN only)
//   out_ready             sink ready
//   out_data, out_valid   registered output word
//   out_last, out_keep    registered side-band (JH_STREAM_UPSIZER_LAST_EN only)
// Macro: JH_STREAM_UPSIZER_LAST_EN enables the last/keep fields.
module jh_stream_out_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
`ifdef JH_STREAM_UPSIZER_LAST_EN
  input  logic              load_last,
  input  logic [KEEP_W-1:0] load_keep,
  output logic              out_last,
  output logic [KEEP_W-1:0] out_keep,
`endif
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      // Drained: data is left as-is, only valid drops.
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;

`ifdef JH_STREAM_UPSIZER_LAST_EN
  logic              r_last;
  logic [KEEP_W-1:0] r_keep;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b0;
      r_keep <= '0;
    end else if (clear) begin
      r_last <= 1'b0;
      r_keep <= '0;
    end else if (load) begin
      r_last <= load_last;
      r_keep <= load_keep;
    end
  end

  assign out_last = r_last;
  assign out_keep = r_keep;
`endif

endmodule

// File: rtl/jh_stream_upsizer.sv
// jh_stream_upsizer: packs RATIO consecutive narrow words into one wide word.
//   Lane 0 (first received) lands in the LSBs. One narrow word per cycle is
//   sustained; the wide word appears one cycle after its last lane is accepted.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   in_data, in_valid, in_ready narrow input stream
//   out_data, out_valid, out_ready wide output stream (registered)
//   clear                      sync flush of partial and held words
//   count                      lanes currently held in the accumulator
//   in_last, out_last, out_keep early packet end support (JH_STREAM_UPSIZER_LAST_EN only)
// Macro: JH_STREAM_UPSIZER_LAST_EN adds in_last/out_last/out_keep and short words.
module jh_stream_upsizer
  import jh_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = JH_DEF_DATA_WIDTH,
  parameter int unsigned RATIO      = JH_DEF_RATIO,
  localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO,
  localparam int unsigned LB_RATIO  = $clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clear,
`ifdef JH_STREAM_UPSIZER_LAST_EN
  input  logic                  in_last,
  output logic                  out_last,
  output logic [RATIO-1:0]      out_keep,
`endif
  output logic [LB_RATIO:0]     count
);

  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("jh_stream_upsizer: RATIO must be a power of 2 and >= 2");
  end

  localparam logic [LB_RATIO-1:0] LANE_MAX = LB_RATIO'(RATIO - 1);

  // Only lanes 0..RATIO-2 are ever stored; the final lane goes straight to the output.
  logic [DATA_WIDTH*(RATIO-1)-1:0] r_acc;
  logic [LB_RATIO-1:0]             r_lane;

  logic                 w_ends;
  logic                 w_in_exec;
  logic                 w_complete;
  logic [OUT_WIDTH-1:0] w_word;

`ifdef JH_STREAM_UPSIZER_LAST_EN
  logic [RATIO-1:0] w_keep;
  assign w_ends = (r_lane == LANE_MAX) || in_last;
`else
  assign w_ends = (r_lane == LANE_MAX);
`endif

  // Only a word-completing beat needs room in the output register.
  assign in_ready   = !w_ends || !out_valid || out_ready;
  assign w_in_exec  = in_valid && in_ready;
  assign w_complete = w_in_exec && w_ends;

  // Assemble the word being completed: stored lanes below r_lane, the incoming
  // word at r_lane, zeros above (only reachable on an early in_last).
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    if (g < RATIO - 1) begin : g_stored
      assign w_word[g*DATA_WIDTH +: DATA_WIDTH] =
        (LB_RATIO'(g) < r_lane)  ? r_acc[g*DATA_WIDTH +: DATA_WIDTH] :
        (LB_RATIO'(g) == r_lane) ? in_data : '0;
    end else begin : g_final
      assign w_word[g*DATA_WIDTH +: DATA_WIDTH] =
        (LB_RATIO'(g) == r_lane) ? in_data : '0;
    end
`ifdef JH_STREAM_UPSIZER_LAST_EN
    assign w_keep[g] = (LB_RATIO'(g) <= r_lane);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (clear) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (w_complete) begin
      // Accumulator left stale; lanes are rewritten before they are next visible.
      r_lane <= '0;
    end else if (w_in_exec) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (r_lane == LB_RATIO'(i)) r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
      end
      r_lane <= r_lane + 1'b1;
    end
  end

  assign count = {1'b0, r_lane};

  jh_stream_out_reg #(
    .WIDTH  (OUT_WIDTH),
    .KEEP_W (RATIO)
  ) u_out_reg (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .load      (w_complete),
    .load_data (w_word),
`ifdef JH_STREAM_UPSIZER_LAST_EN
    .load_last (in_last),
    .load_keep (w_keep),
    .out_last  (out_last),
    .out_keep  (out_keep),
`endif
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

endmodule
